branch_unit: RTL and testbench
==============================

Name: branch_unit

Overview:
- Consumer side of the 8-bit flag bus ZONCIA (bit0 Z, 1 O, 2 N, 3 C, 4 I, 5 A; bits 6–7 unused).
- Owns the program counter.
- Reads the registered flags, evaluates conditional branch, jump-and-link and return instructions, and redirects fetch.
- Signals a one-cycle pipeline flush on every taken redirect.

Parameters:
- PCW, 8, program counter and target width in bits.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active-low; one clock, and reset is synchronous and active-low.
- flags  input  8  registered flag vector from the flag register.
- i  input  5  instruction opcode.
- s  input  3  flag selector for BRF.
- neg  input  1  BRF condition inversion.
- valid  input  1  instruction on i/s/neg/target is valid this cycle.
- stall  input  1  freeze PC, state and outputs.
- target  input  PCW  branch/jump destination.
- pc  output  PCW  current fetch address.
- flush  output  1  high for the redirect cycle; squash in-flight instruction.
- taken  output  1  one-cycle pulse; a redirect occurred.
- link  output  PCW  link register contents.

Behaviour:
- Reset (rst_n=0 at clock edge):
  - pc=RESET_PC, link=0, flush=0, taken=0, state=RUN.
  - Reset overrides stall and any pending flush.
- Opcodes decoded:
  - 5'h1B BRF: conditional branch; cond = flags[s] XOR neg. Selector 0..5 selects Z,O,N,C,I,A. Selector 6,7: cond forced 0, regardless of neg.
  - 5'h1C JAL: unconditional; link <= pc+1 (mod 2^PCW), redirect to target.
  - 5'h1D RET: unconditional; redirect to current link value.
  - All other opcodes: no redirect.
- "Accept" means valid=1, stall=0 and state=RUN.
- State machine, two states:
  - RUN:
    - Accepted redirect (BRF with cond=1, JAL, RET): next pc = destination, next state FLUSH, flush=1 and taken=1 in the following cycle.
    - Otherwise: pc <= pc+1, wrapping 2^PCW-1 -> 0.
  - FLUSH:
    - flush=1, taken=1 for exactly one unstalled cycle.
    - Inputs i/s/neg/target/valid are ignored; the instruction is squashed, and JAL does not write link.
    - pc <= pc+1, state <= RUN.
- Stall:
  - stall=1 holds pc, link, state, flush and taken unchanged in any state.
  - In FLUSH, the flush/taken pulse is stretched until the first unstalled cycle.
- Flags are sampled combinationally in the accept cycle; no extra latency.
- Latency: accept cycle N -> pc=destination and flush=1 in cycle N+1 -> pc=destination+1 in cycle N+2.
- JAL then RET with the same link: RET uses the link value already updated by JAL (at least one cycle apart because of FLUSH).
- valid=0 in RUN: pc increments, no decode.

Test Plan:
- Reset: hold rst_n=0 two cycles with stall=1 -> pc=0, link=0, flush=0, taken=0. Release -> pc counts 1,2,3.
- BRF taken: flags=8'h21 (Z=1,A=1), i=5'h1B, s=0, neg=0, target=8'h40 at pc=8'h05 -> next cycle pc=8'h40, flush=1, taken=1; following cycle pc=8'h41, flush=0.
- BRF not taken / reserved selector:
  - Z=0, s=0, neg=0 -> pc increments, flush=0.
  - s=3'h6, neg=1 -> not taken.
  - s=3'h5 (A), neg=0 -> taken.
- JAL/RET: at pc=8'h10, JAL to 8'h80 -> link=8'h11, pc=8'h80. Later RET -> pc=8'h11 with flush pulse.
- Squash in FLUSH: issue valid JAL during the FLUSH cycle -> ignored; link unchanged, pc=destination+1.
- Wrap and stall:
  - At pc=8'hFF, no branch -> pc=8'h00.
  - Assert stall during FLUSH for 3 cycles -> pc and flush=1 held; after release, one more flush cycle, then RUN.
  - Assert rst_n=0 during FLUSH -> pc=0, flush=0 next cycle.

Source files
------------

// File: rtl/branch_unit.sv
// Branch unit: owns the program counter, evaluates BRF/JAL/RET against the
// registered ZONCIA flags and redirects fetch with a one-cycle flush pulse.
module branch_unit #(
   parameter int unsigned         PCW      = 8,
   parameter logic [PCW-1:0]      RESET_PC = '0
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [7:0]     flags,
   input  logic [4:0]     i,
   input  logic [2:0]     s,
   input  logic           neg,
   input  logic           valid,
   input  logic           stall,
   input  logic [PCW-1:0] target,
   output logic [PCW-1:0] pc,
   output logic           flush,
   output logic           taken,
   output logic [PCW-1:0] link
);

   localparam logic [4:0] OP_BRF = 5'h1B;
   localparam logic [4:0] OP_JAL = 5'h1C;
   localparam logic [4:0] OP_RET = 5'h1D;
   localparam logic [2:0] SEL_MAX = 3'd5;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_e;

   state_e         state_q;
   logic [PCW-1:0] pc_q;
   logic [PCW-1:0] link_q;
   logic           flush_q;
   logic           taken_q;

   logic           accept;
   logic           is_brf;
   logic           is_jal;
   logic           is_ret;
   logic           brf_cond;
   logic           redirect;
   logic [PCW-1:0] pc_inc;
   logic [PCW-1:0] dest;

   // Decode and condition evaluation for the instruction presented this cycle
   always_comb begin
      accept   = valid && !stall && (state_q == ST_RUN);
      is_brf   = (i == OP_BRF);
      is_jal   = (i == OP_JAL);
      is_ret   = (i == OP_RET);
      // Selectors 6 and 7 name no flag; the condition is false even when inverted
      brf_cond = (s <= SEL_MAX) && (flags[s] ^ neg);
      redirect = accept && ((is_brf && brf_cond) || is_jal || is_ret);
      pc_inc   = pc_q + PCW'(1);
      dest     = is_ret ? link_q : target;
   end

   // PC, link, state and the registered flush/taken pulse
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         pc_q    <= RESET_PC;
         link_q  <= '0;
         flush_q <= 1'b0;
         taken_q <= 1'b0;
      end else if (!stall) begin
         case (state_q)
            ST_RUN: begin
               if (redirect) begin
                  pc_q    <= dest;
                  state_q <= ST_FLUSH;
                  flush_q <= 1'b1;
                  taken_q <= 1'b1;
                  if (is_jal) begin
                     link_q <= pc_inc;
                  end
               end else begin
                  pc_q    <= pc_inc;
                  flush_q <= 1'b0;
                  taken_q <= 1'b0;
               end
            end
            ST_FLUSH: begin
               // The instruction in this slot is squashed regardless of its inputs
               pc_q    <= pc_inc;
               state_q <= ST_RUN;
               flush_q <= 1'b0;
               taken_q <= 1'b0;
            end
            default: begin
               state_q <= ST_RUN;
               flush_q <= 1'b0;
               taken_q <= 1'b0;
            end
         endcase
      end
   end

   assign pc    = pc_q;
   assign link  = link_q;
   assign flush = flush_q;
   assign taken = taken_q;

endmodule

// File: tb/tb_branch_unit.sv
// Scoreboard bench for branch_unit: a cycle-level reference model predicts
// pc/link/flush/taken per clock; a monitor compares the DUT against it.
module tb_branch_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] flags;
   logic [4:0] i;
   logic [2:0] s;
   logic       neg;
   logic       valid;
   logic       stall;
   logic [7:0] target;
   logic [7:0] pc;
   logic       flush;
   logic       taken;
   logic [7:0] link;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] pc;
      logic [7:0] link;
      logic       flush;
      logic       taken;
   } exp_t;

   exp_t exp_q[$];

   // Reference model state
   int m_pc   = 0;
   int m_link = 0;
   bit m_in_flush = 0;

   branch_unit #(.PCW(8), .RESET_PC(8'h00)) dut (
      .clk(clk), .rst_n(rst_n), .flags(flags), .i(i), .s(s), .neg(neg),
      .valid(valid), .stall(stall), .target(target),
      .pc(pc), .flush(flush), .taken(taken), .link(link)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: every clock the DUT presents new outputs, compare with the oldest prediction
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pc",    int'(pc),    int'(e.pc));
            chk("link",  int'(link),  int'(e.link));
            chk("flush", int'(flush), int'(e.flush));
            chk("taken", int'(taken), int'(e.taken));
         end
      end
   end

   // Drive one cycle of inputs and predict the outputs after the next rising edge
   task automatic step(input bit r, input bit st, input bit v, input logic [4:0] op,
                       input logic [2:0] sel, input bit ng, input logic [7:0] fl,
                       input logic [7:0] tg);
      exp_t e;
      bit   cond;
      @(negedge clk);
      rst_n = r; stall = st; valid = v; i = op; s = sel; neg = ng;
      flags = fl; target = tg;
      if (!r) begin
         m_pc = 0; m_link = 0; m_in_flush = 0;
      end else if (st) begin
         // frozen
      end else if (m_in_flush) begin
         m_pc = (m_pc + 1) % 256;
         m_in_flush = 0;
      end else if (v && op == 5'h1C) begin
         m_link = (m_pc + 1) % 256;
         m_pc = int'(tg);
         m_in_flush = 1;
      end else if (v && op == 5'h1D) begin
         m_pc = m_link;
         m_in_flush = 1;
      end else if (v && op == 5'h1B) begin
         cond = (sel <= 3'd5) ? ((((int'(fl) >> sel) & 1) == 1) != ng) : 1'b0;
         if (cond) begin
            m_pc = int'(tg);
            m_in_flush = 1;
         end else begin
            m_pc = (m_pc + 1) % 256;
         end
      end else begin
         m_pc = (m_pc + 1) % 256;
      end
      e.pc = 8'(m_pc); e.link = 8'(m_link);
      e.flush = m_in_flush; e.taken = m_in_flush;
      exp_q.push_back(e);
   endtask

   task automatic idle();
      step(1, 0, 0, 5'h00, 3'd0, 0, 8'h00, 8'h00);
   endtask

   // Advance with no instructions until the model pc reaches the wanted value
   task automatic run_to(input int want);
      int n = 0;
      while (m_pc != want && n < 300) begin
         idle();
         n++;
      end
      if (m_pc != want) begin
         errors++;
         $display("FAIL run_to: pc %0h never reached %0h", m_pc, want);
      end
   endtask

   // Direct check of a DUT output just after the coming edge
   task automatic check_after_edge(input string name, input int which, input int req);
      @(posedge clk);
      #2;
      case (which)
         0: chk(name, int'(pc), req);
         1: chk(name, int'(link), req);
         default: chk(name, int'(flush), req);
      endcase
   endtask

   initial begin
      int n;
      logic [4:0] op;
      rst_n = 1'b0; stall = 1'b1; valid = 1'b0; i = '0; s = '0; neg = 1'b0;
      flags = '0; target = '0;

      // Reset under stall, then free-running count
      step(0, 1, 0, 5'h00, 3'd0, 0, 8'h00, 8'h00);
      step(0, 1, 0, 5'h00, 3'd0, 0, 8'h00, 8'h00);
      repeat (3) idle();

      // BRF taken on Z at pc 05
      run_to(8'h05);
      step(1, 0, 1, 5'h1B, 3'd0, 0, 8'h21, 8'h40);
      check_after_edge("brf_dest", 0, 8'h40);
      idle(); idle();

      // BRF not taken: Z clear, reserved selector with neg, then A taken
      step(1, 0, 1, 5'h1B, 3'd0, 0, 8'h00, 8'h90);
      step(1, 0, 1, 5'h1B, 3'd6, 1, 8'hFF, 8'h90);
      step(1, 0, 1, 5'h1B, 3'd7, 1, 8'h00, 8'h90);
      step(1, 0, 1, 5'h1B, 3'd5, 0, 8'h20, 8'h60);
      idle(); idle();

      // JAL from 10 to 80, squashed JAL in the flush slot, then RET
      run_to(8'h10);
      step(1, 0, 1, 5'h1C, 3'd0, 0, 8'h00, 8'h80);
      check_after_edge("jal_link", 1, 8'h11);
      step(1, 0, 1, 5'h1C, 3'd0, 0, 8'h00, 8'h33);
      idle();
      step(1, 0, 1, 5'h1D, 3'd0, 0, 8'h00, 8'h00);
      check_after_edge("ret_pc", 0, 8'h11);
      idle(); idle();

      // Wrap 0xFF -> 0x00
      run_to(8'hFF);
      idle();
      check_after_edge("wrap_pc", 0, 8'h00);

      // Stall during FLUSH for three cycles
      step(1, 0, 1, 5'h1C, 3'd0, 0, 8'h00, 8'hA0);
      repeat (3) step(1, 1, 1, 5'h1D, 3'd0, 0, 8'h00, 8'h00);
      idle(); idle();

      // Reset during FLUSH
      step(1, 0, 1, 5'h1B, 3'd2, 0, 8'h04, 8'hC0);
      step(0, 0, 1, 5'h1C, 3'd0, 0, 8'h00, 8'h55);
      check_after_edge("rst_flush", 2, 0);
      idle();

      // Randomized traffic
      for (int k = 0; k < 3000; k++) begin
         case ($urandom_range(0, 4))
            0: op = 5'h1B;
            1: op = 5'h1B;
            2: op = 5'h1C;
            3: op = 5'h1D;
            default: op = 5'($urandom);
         endcase
         step(($urandom_range(0, 99) != 0), ($urandom_range(0, 4) == 0),
              ($urandom_range(0, 3) != 0), op, 3'($urandom), 1'($urandom),
              8'($urandom), 8'($urandom));
      end

      // Drain outstanding predictions, bounded
      n = 0;
      while (exp_q.size() > 0 && n < 10) begin
         @(posedge clk);
         n++;
      end
      #3;
      chk("drain", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
